// File: rtl/pixel_pack_pkg.sv
// Shared constants and the lane-insertion helper for the 16->128 pixel packer
// and the matching read-side unpacker checks.
package pixel_pack_pkg;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 128;
    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = $clog2(RATIO);

    localparam logic [IN_W-1:0] PAD_RGB565 = 16'h0000;

    // Lanes below idx keep acc, lane idx takes data, lanes above idx take pad.
    function automatic logic [OUT_W-1:0] lane_merge(
        input logic [OUT_W-1:0]  acc,
        input logic [IN_W-1:0]   data,
        input logic [LANE_W-1:0] idx,
        input logic [IN_W-1:0]   pad
    );
        logic [OUT_W-1:0] merged;
        merged = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(idx)) begin
                merged[i*IN_W +: IN_W] = data;
            end else if (i > int'(idx)) begin
                merged[i*IN_W +: IN_W] = pad;
            end
        end
        return merged;
    endfunction
endpackage

// File: rtl/pixel_pack_16to128.sv
// Write-side width up-converter: packs eight 16-bit RGB565 words into one
// 128-bit beat for the frame FIFO, padding partial groups closed by in_last.
module pixel_pack_16to128 #(
    parameter int              IN_W      = pixel_pack_pkg::IN_W,
    parameter int              OUT_W     = pixel_pack_pkg::OUT_W,
    parameter logic [IN_W-1:0] PAD_VALUE = pixel_pack_pkg::PAD_RGB565,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [3:0]       out_fill,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt
);
    import pixel_pack_pkg::*;

    logic [OUT_W-1:0]  r_acc;
    logic [LANE_W-1:0] r_lane;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic [3:0]        r_out_fill;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_close;
    logic              w_handoff;
    logic [OUT_W-1:0]  w_beat;

    // Ready is combinational from out_ready so a beat can leave and the next
    // word be taken in the same cycle without a bubble.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_close    = w_accept && ((r_lane == LANE_W'(RATIO - 1)) || in_last);
    assign w_handoff  = r_out_valid && out_ready;
    assign w_beat     = lane_merge(r_acc, in_data, r_lane, PAD_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_lane      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_fill  <= '0;
        end else begin
            if (w_close) begin
                r_out_data  <= w_beat;
                r_out_valid <= 1'b1;
                r_out_last  <= in_last;
                r_out_fill  <= 4'(r_lane) + 4'd1;
                r_lane      <= '0;
            end else begin
                if (w_accept) begin
                    r_acc  <= w_beat;
                    r_lane <= r_lane + 1'b1;
                end
                if (w_handoff) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_handoff) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_fill  = r_out_fill;
    assign beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_pixel_pack_16to128.sv
// Directed and randomized bench for pixel_pack_16to128 against a queue-based
// reference model of the packing rules.
module tb_pixel_pack_16to128;
    localparam int          IN_W  = 16;
    localparam int          OUT_W = 128;
    localparam int          CNT_W = 4;
    localparam logic [15:0] PAD   = 16'hFFFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic [3:0]       out_fill;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] beat_cnt;

    always #5 clk = ~clk;

    pixel_pack_16to128 #(
        .IN_W(IN_W), .OUT_W(OUT_W), .PAD_VALUE(PAD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_fill(out_fill), .out_ready(out_ready), .beat_cnt(beat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words of the open group, the beat currently offered,
    // and every beat the sink has taken.
    logic [15:0]  grp[$];
    logic [127:0] beats[$];
    logic         m_valid;
    logic [127:0] m_data;
    logic         m_last;
    logic [3:0]   m_fill;
    logic [3:0]   m_cnt;
    logic         accepted;
    logic         pre_rdy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        grp.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_fill  = '0;
        m_cnt   = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_data",  out_data, m_data);
        chk("out_last",  128'(out_last), 128'(m_last));
        chk("out_fill",  128'(out_fill), 128'(m_fill));
        chk("beat_cnt",  128'(beat_cnt), 128'(m_cnt));
    endtask

    // One clock: sample handshake before the edge, advance the model, check after.
    task automatic tick();
        logic        exp_rdy, s_acc, s_hand, s_last;
        logic [15:0] s_data;
        @(negedge clk);
        exp_rdy = !m_valid || out_ready;
        if (rst_n) chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        pre_rdy = in_ready;
        s_acc   = rst_n && in_valid && exp_rdy;
        s_hand  = rst_n && m_valid && out_ready;
        s_data  = in_data;
        s_last  = in_last;
        @(posedge clk);
        #1;
        accepted = s_acc;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (s_hand) begin
                m_cnt++;
                beats.push_back(m_data);
                m_valid = 1'b0;
            end
            if (s_acc) begin
                grp.push_back(s_data);
                if (grp.size() == 8 || s_last) begin
                    for (int j = 0; j < 8; j++)
                        m_data[j*16 +: 16] = (j < grp.size()) ? grp[j] : PAD;
                    m_fill  = 4'(grp.size());
                    m_last  = s_last;
                    m_valid = 1'b1;
                    grp.delete();
                end
            end
        end
        check_outputs();
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (accepted) break;
        end
        chk("send_accepted", 128'(accepted), 128'(1'b1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_async_valid", 128'(out_valid), 128'd0);
        chk("rst_async_data",  out_data, 128'd0);
        chk("rst_async_cnt",   128'(beat_cnt), 128'd0);
        chk("rst_in_ready",    128'(in_ready), 128'd1);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [127:0] pack8(input logic [15:0] w[8]);
        logic [127:0] b;
        for (int j = 0; j < 8; j++) b[j*16 +: 16] = w[j];
        return b;
    endfunction

    initial begin
        logic [15:0]  w[8];
        logic [15:0]  nw[8];
        logic [127:0] saved;
        logic [3:0]   c0;

        model_reset();
        #3;
        chk("reset_in_ready_or0", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_data",  out_data, 128'd0);
        chk("reset_out_last",  128'(out_last), 128'd0);
        chk("reset_out_fill",  128'(out_fill), 128'd0);
        chk("reset_beat_cnt",  128'(beat_cnt), 128'd0);
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready_or1", 128'(in_ready), 128'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full group
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        chk("full_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("full_fill", 128'(out_fill), 128'd8);
        chk("full_last", 128'(out_last), 128'd0);
        idle(1);
        chk("full_cnt", 128'(beat_cnt), 128'd1);

        // Partial group closed by in_last
        send(16'hA001, 1'b0);
        send(16'hA002, 1'b0);
        send(16'hA003, 1'b1);
        chk("part_data", out_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_A003_A002_A001);
        chk("part_fill", 128'(out_fill), 128'd3);
        chk("part_last", 128'(out_last), 128'd1);
        idle(1);

        // Backpressure
        beats.delete();
        for (int i = 0; i < 8; i++) begin
            w[i] = 16'($urandom);
            send(w[i], 1'b0);
        end
        out_ready = 1'b0;
        saved = out_data;
        for (int i = 0; i < 8; i++) nw[i] = 16'($urandom);
        in_valid = 1'b1;
        in_data  = nw[0];
        repeat (5) begin
            tick();
            chk("bp_in_ready", 128'(pre_rdy), 128'd0);
            chk("bp_hold", out_data, saved);
        end
        out_ready = 1'b1;
        send(nw[0], 1'b0);
        for (int i = 1; i < 8; i++) send(nw[i], 1'b0);
        idle(1);
        chk("bp_nbeats", 128'(beats.size()), 128'd2);
        if (beats.size() == 2) begin
            chk("bp_beat0", beats[0], pack8(w));
            chk("bp_beat1", beats[1], pack8(nw));
        end

        // Streaming 64 words
        beats.delete();
        c0 = beat_cnt;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
            chk("stream_ready", 128'(pre_rdy), 128'd1);
        end
        idle(1);
        chk("stream_cnt", 128'(beat_cnt), 128'(4'(c0 + 4'd8)));
        chk("stream_nbeats", 128'(beats.size()), 128'd8);
        if (beats.size() == 8) begin
            for (int k = 0; k < 8; k++)
                for (int j = 0; j < 8; j++)
                    chk("stream_lane", 128'(beats[k][j*16 +: 16]), 128'(8*k + j));
        end

        // Reset mid-group
        for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
        do_reset();
        chk("rst_after_valid", 128'(out_valid), 128'd0);
        for (int i = 0; i < 7; i++) begin
            send(16'hB000 + 16'(i), 1'b0);
            chk("rst_no_early_beat", 128'(out_valid), 128'd0);
        end
        send(16'hB007, 1'b0);
        chk("rst_beat_valid", 128'(out_valid), 128'd1);
        chk("rst_lane0", 128'(out_data[15:0]), 128'h0000_B000);
        chk("rst_fill", 128'(out_fill), 128'd8);
        idle(1);

        // in_last on lane 7
        beats.delete();
        for (int i = 0; i < 8; i++) send(16'($urandom), i == 7);
        chk("l7_fill", 128'(out_fill), 128'd8);
        chk("l7_last", 128'(out_last), 128'd1);
        idle(4);
        chk("l7_nbeats", 128'(beats.size()), 128'd1);
        chk("l7_idle_valid", 128'(out_valid), 128'd0);

        // Counter wrap at 16 beats
        do_reset();
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 8; i++) send(16'($urandom), 1'b0);
        idle(1);
        chk("wrap_cnt", 128'(beat_cnt), 128'd0);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 16'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            tick();
        end
        out_ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end
endmodule

// File: doc/pixel_pack_16to128.md
# pixel_pack_16to128

Write-side width up-converter for the DDR/HDMI loop. It accepts a stream of 16-bit pixel words (RGB565) with a valid/ready handshake and packs each eight words into one 128-bit beat. Partial groups at line or frame ends are padded. It drives the 128-bit write port of the 128→16 frame FIFO and throttles on that FIFO's almost_full.

## Interface
Parameters:
- IN_W, 16, input word width.
- OUT_W, 128, output beat width; must be an integer multiple of IN_W.
- PAD_VALUE, 16'h0000, fill value for unused lanes of a partial beat.
- CNT_W, 16, width of the output beat counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  pixel word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  the word is the last of a line/frame; closes the current beat.
- in_ready  out  1  the block can accept a word this cycle.
- out_data  out  OUT_W  packed beat; the first accepted word sits in [IN_W-1:0].
- out_valid  out  1  out_data holds a beat.
- out_last  out  1  the beat was closed by in_last.
- out_fill  out  4  number of valid lanes in the beat, 1..8.
- out_ready  in  1  the sink takes the beat; wired to ~almost_full && ~wr_full of the FIFO.
- beat_cnt  out  CNT_W  count of beats handed off (out_valid && out_ready); wraps.

## Operation
- RATIO = OUT_W/IN_W = 8. Lane index is 3 bits.
- State:
  - acc[OUT_W-1:0] accumulator.
  - lane[2:0] next lane to write.
  - Output register holding out_data, out_valid, out_last and out_fill.
- in_ready = !out_valid || out_ready. This path is combinational from out_ready.
- Accept = in_valid && in_ready. On accept at lane L:
  - If L==7 or in_last=1, load the output register:
    - Lanes 0..L-1 come from acc.
    - Lane L = in_data.
    - Lanes L+1..7 = PAD_VALUE.
    - out_valid=1, out_last=in_last, out_fill=L+1, lane<=0.
  - Otherwise acc lane L <= in_data and lane <= L+1.
- Hand-off = out_valid && out_ready.
  - beat_cnt increments by 1 modulo 2^CNT_W.
  - out_valid clears unless a new beat loads in the same cycle. If a new beat loads, the output register is overwritten and no bubble is inserted.
- Stale lanes of acc must never appear in out_data. Padding is explicit on every partial beat.
- in_last with in_valid=0 is ignored.
- There is no empty beat: in_last always travels with a word.

## Timing
- Reset values:
  - out_data=0, out_valid=0, out_last=0, out_fill=0, beat_cnt=0.
  - lane=0, acc=0.
  - in_ready=1 while out_ready is held at either level, since out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the 8th word (or the in_last word). The beat is visible the cycle after that accept.
- Throughput: one word per cycle while out_ready=1. The 128-bit side carries one beat per 8 cycles.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0.
  - acc, lane and the output register hold; out_data is stable.
- Simultaneous hand-off and new beat load: the new beat wins and beat_cnt still increments.
- Reset mid-accumulation (rst_n low at any cycle) discards the partial group and any held beat. Outputs return to reset values immediately, asynchronously. The first word after release lands in lane 0.

## Structure
- Shared package pixel_pack_pkg holds:
  - IN_W, OUT_W and RATIO.
  - LANE_W = $clog2(RATIO).
  - A PAD_RGB565 constant.
- Single module with no sub-module. Lane insertion is a function in the package, lane_merge(acc, data, idx, pad), which is also usable by the read-side unpacker checks.

## Test plan
- Full group, out_ready=1:
  - Stimulus: words 16'h0001..16'h0008.
  - Response: out_data=128'h0008_0007_0006_0005_0004_0003_0002_0001, out_fill=8, out_last=0, beat_cnt=1.
- Partial group:
  - Stimulus: 16'hA001, 16'hA002, 16'hA003 with in_last on the third word, PAD_VALUE=16'hFFFF.
  - Response: out_data=128'hFFFF_FFFF_FFFF_FFFF_FFFF_A003_A002_A001, out_fill=3, out_last=1.
- Backpressure:
  - Stimulus: complete a beat, then hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: in_ready=0 throughout, out_data unchanged, no word lost. The next 8 words form the next beat exactly.
- Streaming:
  - Stimulus: 64 consecutive words 0..63 with out_ready=1.
  - Response: 8 beats with no in_ready deassertion and beat_cnt=8. Beat k lane j holds 8k+j.
- Reset mid-group:
  - Stimulus: 5 words accepted, rst_n pulsed low, then 8 words 16'hB000..16'hB007.
  - Response: out_valid=0 during and after reset. A single beat follows with lane 0 = 16'hB000 and out_fill=8.
- in_last on 8th word and counter wrap:
  - in_last on lane 7 gives one beat with out_fill=8, out_last=1, and no extra beat follows.
  - With CNT_W=4, after 16 beats beat_cnt=0.
